xadc_drp_sequencer: RTL and testbench
=====================================

XADC_DRP_SEQUENCER -- requirements
Module: xadc_drp_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max cycles to wait for drdy_in after a DRP read strobe.
REQ-002 SHALL have parameter ADDR_BASE, default 7'h10: DRP address of aux channel 0; aux n is ADDR_BASE+n.
REQ-003 SHALL have ports (one per line):
- CLK100MHZ  in  1  sole clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- ch_mask  in  4  channel enable; bit0=aux6, bit1=aux7, bit2=aux14, bit3=aux15.
- eoc_in  in  1  XADC end-of-conversion pulse; the conversion trigger.
- den_out  out  1  DRP enable strobe.
- dwe_out  out  1  DRP write enable; constant 0.
- daddr_out  out  7  DRP address.
- drdy_in  in  1  DRP data-ready.
- do_in  in  16  DRP read data.
- sample6, sample7, sample14, sample15  out  12 each  latest conversion per channel.
- sample_valid  out  1  one-cycle pulse, new sample latched.
- sample_idx  out  2  index (0..3) of the sample just latched.
- busy  out  1  high while not IDLE.
- overrun  out  1  sticky: eoc_in arrived while busy.
- timeout_err  out  1  sticky: drdy_in missing for TIMEOUT cycles.

Function
REQ-004 SHALL implement FSM states IDLE, ISSUE, WAIT_RDY, CAPTURE.
REQ-005 IDLE: on eoc_in=1 with ch_mask!=0, SHALL select the next enabled index and go to ISSUE; with ch_mask=0, SHALL stay IDLE, no DRP access.
REQ-006 Selection SHALL be round-robin: search starts at last_idx+1, wraps 3->0, takes first enabled bit; last_idx resets to 3, so the first pick after reset is the lowest enabled index >=0.
REQ-007 ISSUE: SHALL drive den_out=1 for exactly one cycle with daddr_out=ADDR_BASE+{0,1,14-8... mapped} where aux index map is idx0->6, idx1->7, idx2->14, idx3->15 (daddr_out=ADDR_BASE+aux number); then WAIT_RDY.
REQ-008 Latency: eoc_in sampled high in cycle N SHALL yield den_out=1 in cycle N+1.
REQ-009 daddr_out SHALL be held stable from ISSUE until leaving WAIT_RDY.
REQ-010 WAIT_RDY: on drdy_in=1 SHALL register do_in[15:4] and go to CAPTURE; drdy_in in the same cycle as den_out is not possible and SHALL be ignored outside WAIT_RDY.
REQ-011 CAPTURE: SHALL write the captured 12-bit value to the selected sample register, pulse sample_valid=1 with sample_idx, update last_idx, return to IDLE; drdy_in in cycle M gives sample_valid in cycle M+1.
REQ-012 WAIT_RDY timeout: a counter SHALL clear on entry and increment each cycle; at TIMEOUT cycles without drdy_in SHALL set timeout_err, leave sample registers unchanged, update last_idx, return to IDLE with no sample_valid.
REQ-013 eoc_in while busy=1 (including the CAPTURE cycle) SHALL be dropped and SHALL set overrun; no queueing.
REQ-014 ch_mask changes SHALL take effect only at the next selection in IDLE; an in-flight read completes normally.
REQ-015 busy SHALL be 1 in ISSUE, WAIT_RDY, CAPTURE; 0 in IDLE.
REQ-016 dwe_out SHALL be 0 always; overrun and timeout_err clear only on reset.

Reset
REQ-017 On reset=1 at a clock edge: state=IDLE, den_out=0, daddr_out=0, all sample registers=0, sample_valid=0, sample_idx=0, busy=0, overrun=0, timeout_err=0, last_idx=3, timeout counter=0.
REQ-018 Reset asserted mid-transaction SHALL abort it; a late drdy_in after reset SHALL be ignored.

Verification
REQ-019 ch_mask=4'b1111, four eoc_in pulses 20 cycles apart, drdy_in 3 cycles after each den_out with do_in=16'hABC0 -> daddr_out 7'h16,7'h17,7'h1E,7'h1F in order; each sample=12'hABC; sample_idx 0,1,2,3.
REQ-020 ch_mask=4'b0100, eoc_in in cycle N -> den_out in N+1, daddr_out=7'h1E; drdy_in in M with do_in=16'h1234 -> sample14=12'h123, sample_valid in M+1 only.
REQ-021 ch_mask=0, eoc_in pulses -> den_out never asserts, busy stays 0.
REQ-022 eoc_in during WAIT_RDY -> overrun=1, no extra den_out; current read completes.
REQ-023 drdy_in withheld -> timeout_err=1 after 255 WAIT_RDY cycles, FSM IDLE, samples unchanged; next eoc_in reads next enabled channel.
REQ-024 reset asserted in WAIT_RDY, then drdy_in -> all outputs at reset values, no sample_valid.

Source files
------------

// File: rtl/xadc_drp_sequencer.sv
// rtl/xadc_drp_sequencer.sv - round-robin DRP reader for XADC aux channels 6, 7, 14, 15
// Each eoc_in triggers one DRP read of the next enabled channel; results land in per-channel registers.
module xadc_drp_sequencer #(
    parameter int         TIMEOUT   = 255,
    parameter logic [6:0] ADDR_BASE = 7'h10
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic [3:0]  ch_mask,
    input  logic        eoc_in,
    output logic        den_out,
    output logic        dwe_out,
    output logic [6:0]  daddr_out,
    input  logic        drdy_in,
    input  logic [15:0] do_in,
    output logic [11:0] sample6,
    output logic [11:0] sample7,
    output logic [11:0] sample14,
    output logic [11:0] sample15,
    output logic        sample_valid,
    output logic [1:0]  sample_idx,
    output logic        busy,
    output logic        overrun,
    output logic        timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RDY, CAPTURE} state_t;

    state_t        state, state_nxt;
    logic [1:0]    last_idx;
    logic [1:0]    sel_idx;
    logic [1:0]    pick_idx;
    logic          pick_ok;
    logic [CW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic [11:0]   smp [4];
    logic          unused_low;

    function automatic logic [6:0] aux_addr(input logic [1:0] idx);
        logic [6:0] aux;
        case (idx)
            2'd0:    aux = 7'd6;
            2'd1:    aux = 7'd7;
            2'd2:    aux = 7'd14;
            default: aux = 7'd15;
        endcase
        return ADDR_BASE + aux;
    endfunction

    // Search starts one past the last serviced index; k=4 wraps back onto last_idx itself.
    always_comb begin
        pick_ok  = 1'b0;
        pick_idx = last_idx;
        for (int k = 1; k <= 4; k++) begin
            if (!pick_ok && ch_mask[last_idx + 2'(k)]) begin
                pick_ok  = 1'b1;
                pick_idx = last_idx + 2'(k);
            end
        end
    end

    assign tmo_hit    = (tmo_cnt == CW'(TIMEOUT - 1));
    assign dwe_out    = 1'b0;
    assign sample6    = smp[0];
    assign sample7    = smp[1];
    assign sample14   = smp[2];
    assign sample15   = smp[3];
    assign unused_low = ^do_in[3:0];

    always_comb begin
        state_nxt    = state;
        den_out      = 1'b0;
        sample_valid = 1'b0;
        busy         = (state != IDLE);
        case (state)
            IDLE:     if (eoc_in && pick_ok) state_nxt = ISSUE;
            ISSUE: begin
                den_out   = 1'b1;
                state_nxt = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (drdy_in)      state_nxt = CAPTURE;
                else if (tmo_hit) state_nxt = IDLE;
            end
            CAPTURE: begin
                sample_valid = 1'b1;
                state_nxt    = IDLE;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state       <= IDLE;
            daddr_out   <= 7'd0;
            sample_idx  <= 2'd0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
            last_idx    <= 2'd3;
            sel_idx     <= 2'd0;
            tmo_cnt     <= '0;
            for (int i = 0; i < 4; i++) smp[i] <= 12'd0;
        end else begin
            state <= state_nxt;
            if (eoc_in && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (eoc_in && pick_ok) begin
                        sel_idx   <= pick_idx;
                        daddr_out <= aux_addr(pick_idx);
                    end
                end
                ISSUE: tmo_cnt <= '0;
                WAIT_RDY: begin
                    // Sample register is written here so it is already visible while sample_valid is high.
                    if (drdy_in) begin
                        smp[sel_idx] <= do_in[15:4];
                        sample_idx   <= sel_idx;
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        last_idx    <= sel_idx;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                CAPTURE: last_idx <= sel_idx;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// tb/tb_xadc_drp_sequencer.sv - scoreboard bench for xadc_drp_sequencer
module tb_xadc_drp_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  ch_mask = 4'd0;
    logic        eoc_in = 1'b0;
    logic        drdy_in = 1'b0;
    logic [15:0] do_in = 16'd0;
    logic        den_out, dwe_out, sample_valid, busy, overrun, timeout_err;
    logic [6:0]  daddr_out;
    logic [11:0] sample6, sample7, sample14, sample15;
    logic [1:0]  sample_idx;

    int n_checks = 0;
    int n_pass   = 0;
    logic [6:0]  addr_q [$];
    logic [13:0] smp_q  [$];
    logic [6:0]  rr_addr [4] = '{7'h16, 7'h17, 7'h1E, 7'h1F};

    always #5 clk = ~clk;

    xadc_drp_sequencer dut (
        .CLK100MHZ(clk), .reset(reset), .ch_mask(ch_mask), .eoc_in(eoc_in),
        .den_out(den_out), .dwe_out(dwe_out), .daddr_out(daddr_out),
        .drdy_in(drdy_in), .do_in(do_in),
        .sample6(sample6), .sample7(sample7), .sample14(sample14), .sample15(sample15),
        .sample_valid(sample_valid), .sample_idx(sample_idx),
        .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
    );

    function automatic logic [11:0] sample_of(input logic [1:0] i);
        case (i)
            2'd0:    return sample6;
            2'd1:    return sample7;
            2'd2:    return sample14;
            default: return sample15;
        endcase
    endfunction

    always @(negedge clk) begin
        logic [6:0]  ea;
        logic [13:0] es;
        if (den_out === 1'b1) begin
            n_checks++;
            if (addr_q.size() == 0) $display("FAIL den_addr: unexpected den_out, daddr=%h", daddr_out);
            else begin
                ea = addr_q.pop_front();
                if (daddr_out !== ea) $display("FAIL den_addr: got %h expected %h", daddr_out, ea);
                else n_pass++;
            end
        end
        if (sample_valid === 1'b1) begin
            n_checks++;
            if (smp_q.size() == 0) $display("FAIL sample: unexpected sample_valid, idx=%0d", sample_idx);
            else begin
                es = smp_q.pop_front();
                if (sample_idx !== es[13:12] || sample_of(es[13:12]) !== es[11:0])
                    $display("FAIL sample: got idx %0d val %h expected idx %0d val %h",
                             sample_idx, sample_of(es[13:12]), es[13:12], es[11:0]);
                else n_pass++;
            end
        end
    end

    task automatic pulse_eoc();
        @(posedge clk); #1 eoc_in = 1'b1;
        @(posedge clk); #1 eoc_in = 1'b0;
    endtask

    task automatic give_drdy(input int dly, input logic [15:0] d);
        repeat (dly) @(posedge clk);
        #1 drdy_in = 1'b1; do_in = d;
        @(posedge clk); #1 drdy_in = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({den_out, dwe_out, sample_valid, busy, overrun, timeout_err} !== 6'b0)
            $display("FAIL reset_flags: got %b expected 000000",
                     {den_out, dwe_out, sample_valid, busy, overrun, timeout_err});
        else n_pass++;
        n_checks++;
        if (daddr_out !== 7'h00) $display("FAIL reset_daddr: got %h expected 00", daddr_out);
        else n_pass++;
        n_checks++;
        if ({sample6, sample7, sample14, sample15, sample_idx} !== 50'h0)
            $display("FAIL reset_samples: got %h %h %h %h idx %0d expected all 0",
                     sample6, sample7, sample14, sample15, sample_idx);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        ch_mask = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            addr_q.push_back(rr_addr[i]);
            pulse_eoc();
            @(negedge clk);
            n_checks++;
            if (den_out !== 1'b1) $display("FAIL rr_latency: got den %b expected 1", den_out);
            else n_pass++;
            smp_q.push_back({i[1:0], 12'hABC});
            give_drdy(3, 16'hABC0);
            repeat (14) @(posedge clk);
        end
        n_checks++;
        if ({sample6, sample7, sample14, sample15} !== {4{12'hABC}})
            $display("FAIL rr_samples: got %h %h %h %h expected abc x4", sample6, sample7, sample14, sample15);
        else n_pass++;
    endtask

    task automatic test_single();
        ch_mask = 4'b0100;
        addr_q.push_back(7'h1E);
        pulse_eoc();
        @(negedge clk);
        n_checks++;
        if (den_out !== 1'b1 || daddr_out !== 7'h1E)
            $display("FAIL single_issue: got den %b addr %h expected 1 1e", den_out, daddr_out);
        else n_pass++;
        @(posedge clk); #1;
        @(posedge clk); #1 drdy_in = 1'b1; do_in = 16'h1234;
        smp_q.push_back({2'd2, 12'h123});
        @(negedge clk);
        n_checks++;
        if (sample_valid !== 1'b0) $display("FAIL single_valid_m: got %b expected 0", sample_valid);
        else n_pass++;
        @(posedge clk); #1 drdy_in = 1'b0;
        @(negedge clk);
        n_checks++;
        if (sample_valid !== 1'b1 || sample14 !== 12'h123)
            $display("FAIL single_valid_m1: got valid %b s14 %h expected 1 123", sample_valid, sample14);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (sample_valid !== 1'b0) $display("FAIL single_valid_m2: got %b expected 0", sample_valid);
        else n_pass++;
    endtask

    task automatic test_mask_zero();
        logic bad;
        ch_mask = 4'b0000;
        for (int p = 0; p < 3; p++) begin
            bad = 1'b0;
            pulse_eoc();
            repeat (4) @(negedge clk) if (den_out !== 1'b0 || busy !== 1'b0) bad = 1'b1;
            n_checks++;
            if (bad) $display("FAIL mask_zero: got activity with mask 0, pulse %0d, expected none", p);
            else n_pass++;
        end
        n_checks++;
        if (overrun !== 1'b0) $display("FAIL mask_zero_overrun: got %b expected 0", overrun);
        else n_pass++;
    endtask

    task automatic test_overrun();
        ch_mask = 4'b1111;
        addr_q.push_back(7'h1F);
        pulse_eoc();
        @(posedge clk); #1 eoc_in = 1'b1;
        @(posedge clk); #1 eoc_in = 1'b0;
        @(negedge clk);
        n_checks++;
        if (overrun !== 1'b1) $display("FAIL overrun_set: got %b expected 1", overrun);
        else n_pass++;
        smp_q.push_back({2'd3, 12'h5A5});
        give_drdy(1, 16'h5A5F);
        @(negedge clk);
        n_checks++;
        if (sample15 !== 12'h5A5) $display("FAIL overrun_read: got %h expected 5a5", sample15);
        else n_pass++;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_timeout();
        int n;
        addr_q.push_back(7'h16);
        pulse_eoc();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy === 1'b1 && n < 400);
        n_checks++;
        if (n - 2 != 255) $display("FAIL timeout_len: got %0d wait cycles expected 255", n - 2);
        else n_pass++;
        n_checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0)
            $display("FAIL timeout_flag: got err %b busy %b expected 1 0", timeout_err, busy);
        else n_pass++;
        n_checks++;
        if (sample6 !== 12'hABC) $display("FAIL timeout_keep: got %h expected abc", sample6);
        else n_pass++;
        addr_q.push_back(7'h17);
        pulse_eoc();
        smp_q.push_back({2'd1, 12'h777});
        give_drdy(2, 16'h7770);
        @(negedge clk);
        n_checks++;
        if (sample7 !== 12'h777) $display("FAIL timeout_next: got %h expected 777", sample7);
        else n_pass++;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        logic bad;
        addr_q.push_back(7'h1E);
        pulse_eoc();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0; drdy_in = 1'b1; do_in = 16'hFFF0;
        @(posedge clk); #1 drdy_in = 1'b0;
        bad = 1'b0;
        repeat (3) @(negedge clk) if (sample_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        n_checks++;
        if (bad) $display("FAIL rst_mid_late_drdy: got activity after reset expected none");
        else n_pass++;
        n_checks++;
        if ({overrun, timeout_err, daddr_out, sample_idx} !== 11'h0)
            $display("FAIL rst_mid_regs: got ovr %b tmo %b addr %h idx %0d expected 0",
                     overrun, timeout_err, daddr_out, sample_idx);
        else n_pass++;
        n_checks++;
        if ({sample6, sample7, sample14, sample15} !== 48'h0)
            $display("FAIL rst_mid_samples: got %h %h %h %h expected 0", sample6, sample7, sample14, sample15);
        else n_pass++;
        ch_mask = 4'b0001;
        addr_q.push_back(7'h16);
        pulse_eoc();
        smp_q.push_back({2'd0, 12'h321});
        give_drdy(1, 16'h3210);
        @(negedge clk);
        n_checks++;
        if (sample6 !== 12'h321) $display("FAIL rst_mid_after: got %h expected 321", sample6);
        else n_pass++;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_mask_zero();
        test_overrun();
        test_timeout();
        test_reset_mid();
        n_checks++;
        if (addr_q.size() != 0 || smp_q.size() != 0)
            $display("FAIL scoreboard_drain: got %0d addr %0d samples pending expected 0 0",
                     addr_q.size(), smp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
